// File: rtl/decode_cycle.sv
// RV32I decode stage: 32x32 register file with write-back bypass, immediate and
// control decode, load-use stall detection and the D/E pipeline register.
module decode_cycle #(
  parameter bit WB_BYPASS      = 1'b1,
  parameter bit NOP_ON_ILLEGAL = 1'b1
) (
  input  logic        clk_i,
  input  logic        asynch_rst,
  input  logic [31:0] instr_D,
  input  logic [31:0] pc_D,
  input  logic        is_taken_E,
  input  logic        rd_wren_W,
  input  logic [4:0]  rd_addr_W,
  input  logic [31:0] rd_data_W,
  output logic        stall,
  output logic        valid_E,
  output logic [31:0] pc_E,
  output logic [31:0] rs1_data_E,
  output logic [31:0] rs2_data_E,
  output logic [31:0] imm_E,
  output logic [4:0]  rs1_addr_E,
  output logic [4:0]  rs2_addr_E,
  output logic [4:0]  rd_addr_E,
  output logic [15:0] ctrl_E,
  output logic        illegal_E
);

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OPIMM  = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_e;

  logic [31:0] regs [32];

  opcode_e     opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1_idx, rs2_idx, rd_idx;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  logic        reg_wren, mem_read, mem_write, branch, jump, alu_src_imm, op_a_pc;
  logic        uses_rs1, uses_rs2, known;
  logic [1:0]  wb_sel;
  alu_op_e     alu_op, alu_arith;
  logic [2:0]  ctrl_funct3;
  logic [31:0] imm;
  logic [15:0] ctrl;
  logic [31:0] rs1_val, rs2_val;
  logic        instr_zero, illegal, load_use;

  assign opcode  = opcode_e'(instr_D[6:0]);
  assign funct3  = instr_D[14:12];
  assign rs1_idx = instr_D[19:15];
  assign rs2_idx = instr_D[24:20];
  assign rd_idx  = instr_D[11:7];

  assign imm_i = {{20{instr_D[31]}}, instr_D[31:20]};
  assign imm_s = {{20{instr_D[31]}}, instr_D[31:25], instr_D[11:7]};
  assign imm_b = {{19{instr_D[31]}}, instr_D[31], instr_D[7], instr_D[30:25], instr_D[11:8], 1'b0};
  assign imm_u = {instr_D[31:12], 12'h000};
  assign imm_j = {{11{instr_D[31]}}, instr_D[31], instr_D[19:12], instr_D[20], instr_D[30:21], 1'b0};

  // instr[30] selects SUB only for register-register ops; ADDI reuses that bit as immediate
  always_comb begin
    alu_arith = ALU_ADD;
    case (funct3)
      3'b000: alu_arith = (opcode == OPC_OP && instr_D[30]) ? ALU_SUB : ALU_ADD;
      3'b001: alu_arith = ALU_SLL;
      3'b010: alu_arith = ALU_SLT;
      3'b011: alu_arith = ALU_SLTU;
      3'b100: alu_arith = ALU_XOR;
      3'b101: alu_arith = instr_D[30] ? ALU_SRA : ALU_SRL;
      3'b110: alu_arith = ALU_OR;
      default: alu_arith = ALU_AND;
    endcase
  end

  always_comb begin
    reg_wren    = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    branch      = 1'b0;
    jump        = 1'b0;
    alu_src_imm = 1'b0;
    op_a_pc     = 1'b0;
    wb_sel      = 2'd0;
    alu_op      = ALU_ADD;
    ctrl_funct3 = 3'd0;
    uses_rs1    = 1'b0;
    uses_rs2    = 1'b0;
    known       = 1'b1;
    imm         = '0;
    case (opcode)
      OPC_LUI: begin
        reg_wren = 1'b1; alu_src_imm = 1'b1; alu_op = ALU_PASSB; imm = imm_u;
      end
      OPC_AUIPC: begin
        reg_wren = 1'b1; alu_src_imm = 1'b1; op_a_pc = 1'b1; imm = imm_u;
      end
      OPC_JAL: begin
        reg_wren = 1'b1; jump = 1'b1; alu_src_imm = 1'b1; op_a_pc = 1'b1;
        wb_sel = 2'd2; imm = imm_j;
      end
      OPC_JALR: begin
        reg_wren = 1'b1; jump = 1'b1; alu_src_imm = 1'b1; wb_sel = 2'd2;
        uses_rs1 = 1'b1; ctrl_funct3 = funct3; imm = imm_i;
      end
      OPC_BRANCH: begin
        branch = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; alu_op = ALU_SUB;
        ctrl_funct3 = funct3; imm = imm_b;
      end
      OPC_LOAD: begin
        reg_wren = 1'b1; mem_read = 1'b1; alu_src_imm = 1'b1; wb_sel = 2'd1;
        uses_rs1 = 1'b1; ctrl_funct3 = funct3; imm = imm_i;
      end
      OPC_STORE: begin
        mem_write = 1'b1; alu_src_imm = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        ctrl_funct3 = funct3; imm = imm_s;
      end
      OPC_OPIMM: begin
        reg_wren = 1'b1; alu_src_imm = 1'b1; uses_rs1 = 1'b1; alu_op = alu_arith;
        ctrl_funct3 = funct3; imm = imm_i;
      end
      OPC_OP: begin
        reg_wren = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; alu_op = alu_arith;
        ctrl_funct3 = funct3;
      end
      default: known = 1'b0;
    endcase
  end

  assign ctrl = {ctrl_funct3, alu_op, wb_sel, op_a_pc, alu_src_imm, jump, branch,
                 mem_write, mem_read, reg_wren};

  // Same-edge write-back is visible to the decode read through the bypass
  always_comb begin
    rs1_val = regs[rs1_idx];
    rs2_val = regs[rs2_idx];
    if (WB_BYPASS && rd_wren_W && rd_addr_W == rs1_idx) rs1_val = rd_data_W;
    if (WB_BYPASS && rd_wren_W && rd_addr_W == rs2_idx) rs2_val = rd_data_W;
    if (rs1_idx == 5'd0) rs1_val = '0;
    if (rs2_idx == 5'd0) rs2_val = '0;
  end

  assign instr_zero = (instr_D == 32'd0);
  assign illegal    = !known && !instr_zero;

  assign load_use = valid_E && ctrl_E[1] && (rd_addr_E != 5'd0) &&
                    ((uses_rs1 && rs1_idx == rd_addr_E) || (uses_rs2 && rs2_idx == rd_addr_E));
  assign stall    = load_use && !is_taken_E;

  always_ff @(posedge clk_i or negedge asynch_rst) begin
    if (!asynch_rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (rd_wren_W && rd_addr_W != 5'd0) begin
      regs[rd_addr_W] <= rd_data_W;
    end
  end

  always_ff @(posedge clk_i or negedge asynch_rst) begin
    if (!asynch_rst) begin
      valid_E    <= 1'b0;
      pc_E       <= '0;
      rs1_data_E <= '0;
      rs2_data_E <= '0;
      imm_E      <= '0;
      rs1_addr_E <= '0;
      rs2_addr_E <= '0;
      rd_addr_E  <= '0;
      ctrl_E     <= '0;
      illegal_E  <= 1'b0;
    end else if (is_taken_E || stall || instr_zero || (illegal && NOP_ON_ILLEGAL)) begin
      valid_E    <= 1'b0;
      pc_E       <= '0;
      rs1_data_E <= '0;
      rs2_data_E <= '0;
      imm_E      <= '0;
      rs1_addr_E <= '0;
      rs2_addr_E <= '0;
      rd_addr_E  <= '0;
      ctrl_E     <= '0;
      illegal_E  <= illegal && !is_taken_E && !stall;
    end else begin
      valid_E    <= 1'b1;
      pc_E       <= pc_D;
      rs1_data_E <= uses_rs1 ? rs1_val : 32'd0;
      rs2_data_E <= uses_rs2 ? rs2_val : 32'd0;
      imm_E      <= imm;
      rs1_addr_E <= uses_rs1 ? rs1_idx : 5'd0;
      rs2_addr_E <= uses_rs2 ? rs2_idx : 5'd0;
      rd_addr_E  <= reg_wren ? rd_idx : 5'd0;
      ctrl_E     <= ctrl;
      illegal_E  <= illegal;
    end
  end

endmodule

// File: tb/tb_decode_cycle.sv
// Bench for decode_cycle: a per-cycle reference model of the decode stage plus
// directed instruction sequences with hand-computed literal expectations.
module tb_decode_cycle;

  logic        clk_i = 1'b0;
  logic        asynch_rst;
  logic [31:0] instr_D;
  logic [31:0] pc_D;
  logic        is_taken_E;
  logic        rd_wren_W;
  logic [4:0]  rd_addr_W;
  logic [31:0] rd_data_W;
  logic        stall;
  logic        valid_E;
  logic [31:0] pc_E;
  logic [31:0] rs1_data_E;
  logic [31:0] rs2_data_E;
  logic [31:0] imm_E;
  logic [4:0]  rs1_addr_E;
  logic [4:0]  rs2_addr_E;
  logic [4:0]  rd_addr_E;
  logic [15:0] ctrl_E;
  logic        illegal_E;

  decode_cycle dut (
    .clk_i(clk_i), .asynch_rst(asynch_rst), .instr_D(instr_D), .pc_D(pc_D),
    .is_taken_E(is_taken_E), .rd_wren_W(rd_wren_W), .rd_addr_W(rd_addr_W),
    .rd_data_W(rd_data_W), .stall(stall), .valid_E(valid_E), .pc_E(pc_E),
    .rs1_data_E(rs1_data_E), .rs2_data_E(rs2_data_E), .imm_E(imm_E),
    .rs1_addr_E(rs1_addr_E), .rs2_addr_E(rs2_addr_E), .rd_addr_E(rd_addr_E),
    .ctrl_E(ctrl_E), .illegal_E(illegal_E)
  );

  always #5 clk_i = ~clk_i;

  // alu_op encoding is internal to the datapath, so it is left out of the comparison
  localparam logic [15:0] CTRL_MASK = 16'hE1FF;

  typedef struct packed {
    logic        known;
    logic        rd1;
    logic        rd2;
    logic        wr;
    logic [15:0] ctrl;
    logic [31:0] imm;
  } dec_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [4:0]  rs1a;
    logic [4:0]  rs2a;
    logic [4:0]  rda;
    logic [15:0] ctrl;
    logic        ill;
  } e_t;

  int          n_total = 0;
  int          n_bad   = 0;
  logic        check_en = 1'b0;
  logic [31:0] model_rf [32];
  e_t          exp_e;
  dec_t        md;
  dec_t        md_c;
  logic [4:0]  m_rs1, m_rs2;

  logic [31:0] prog [11] = '{
    32'h00532223, 32'h010000EF, 32'h00001517, 32'h00008067, 32'h407284B3,
    32'h00012083, 32'h00132023, 32'h4032D293, 32'h00209463, 32'h00012083,
    32'h001201B3
  };

  function automatic dec_t model_decode(input logic [31:0] ins);
    dec_t d;
    logic signed [11:0] i12;
    logic signed [11:0] s12;
    logic signed [12:0] b13;
    logic signed [20:0] j21;
    i12 = ins[31:20];
    s12 = {ins[31:25], ins[11:7]};
    b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    d = '0;
    d.known = 1'b1;
    case (ins[6:0])
      7'b0110111: begin d.wr = 1; d.ctrl[5] = 1; d.imm = {ins[31:12], 12'h000}; end
      7'b0010111: begin d.wr = 1; d.ctrl[5] = 1; d.ctrl[6] = 1; d.imm = {ins[31:12], 12'h000}; end
      7'b1101111: begin
        d.wr = 1; d.ctrl[4] = 1; d.ctrl[5] = 1; d.ctrl[6] = 1; d.ctrl[8:7] = 2'd2; d.imm = 32'(j21);
      end
      7'b1100111: begin
        d.wr = 1; d.rd1 = 1; d.ctrl[4] = 1; d.ctrl[5] = 1; d.ctrl[8:7] = 2'd2;
        d.ctrl[15:13] = ins[14:12]; d.imm = 32'(i12);
      end
      7'b1100011: begin
        d.rd1 = 1; d.rd2 = 1; d.ctrl[3] = 1; d.ctrl[15:13] = ins[14:12]; d.imm = 32'(b13);
      end
      7'b0000011: begin
        d.wr = 1; d.rd1 = 1; d.ctrl[1] = 1; d.ctrl[5] = 1; d.ctrl[8:7] = 2'd1;
        d.ctrl[15:13] = ins[14:12]; d.imm = 32'(i12);
      end
      7'b0100011: begin
        d.rd1 = 1; d.rd2 = 1; d.ctrl[2] = 1; d.ctrl[5] = 1;
        d.ctrl[15:13] = ins[14:12]; d.imm = 32'(s12);
      end
      7'b0010011: begin
        d.wr = 1; d.rd1 = 1; d.ctrl[5] = 1; d.ctrl[15:13] = ins[14:12]; d.imm = 32'(i12);
      end
      7'b0110011: begin d.wr = 1; d.rd1 = 1; d.rd2 = 1; d.ctrl[15:13] = ins[14:12]; end
      default: d.known = 1'b0;
    endcase
    d.ctrl[0] = d.wr;
    return d;
  endfunction

  function automatic logic model_hazard(input dec_t d, input logic [31:0] ins,
                                        input e_t e, input logic taken);
    logic hit;
    hit = (d.rd1 && ins[19:15] == e.rda) || (d.rd2 && ins[24:20] == e.rda);
    return e.valid && e.ctrl[1] && (e.rda != 5'd0) && hit && !taken;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] pc, input logic taken,
                               input logic wren, input logic [4:0] waddr, input logic [31:0] wdata);
    instr_D    = ins;
    pc_D       = pc;
    is_taken_E = taken;
    rd_wren_W  = wren;
    rd_addr_W  = waddr;
    rd_data_W  = wdata;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reference model: write-back lands first, so a same-edge read sees it
  always @(posedge clk_i or negedge asynch_rst) begin
    if (!asynch_rst) begin
      exp_e = '0;
      for (int i = 0; i < 32; i++) model_rf[i] = '0;
    end else begin
      if (rd_wren_W && rd_addr_W != 5'd0) model_rf[rd_addr_W] = rd_data_W;
      md = model_decode(instr_D);
      if (is_taken_E || model_hazard(md, instr_D, exp_e, is_taken_E) || instr_D == 32'd0) begin
        exp_e = '0;
      end else if (!md.known) begin
        exp_e = '0;
        exp_e.ill = 1'b1;
      end else begin
        m_rs1 = md.rd1 ? instr_D[19:15] : 5'd0;
        m_rs2 = md.rd2 ? instr_D[24:20] : 5'd0;
        exp_e.valid = 1'b1;
        exp_e.pc    = pc_D;
        exp_e.rs1a  = m_rs1;
        exp_e.rs2a  = m_rs2;
        exp_e.rs1d  = model_rf[m_rs1];
        exp_e.rs2d  = model_rf[m_rs2];
        exp_e.rda   = md.wr ? instr_D[11:7] : 5'd0;
        exp_e.imm   = md.imm;
        exp_e.ctrl  = md.ctrl;
        exp_e.ill   = 1'b0;
      end
    end
  end

  always @(negedge clk_i) begin
    if (check_en) begin
      md_c = model_decode(instr_D);
      checkOutput("stall", 32'(stall), 32'(model_hazard(md_c, instr_D, exp_e, is_taken_E)));
      checkOutput("valid_E", 32'(valid_E), 32'(exp_e.valid));
      checkOutput("illegal_E", 32'(illegal_E), 32'(exp_e.ill));
      checkOutput("pc_E", pc_E, exp_e.pc);
      checkOutput("rs1_data_E", rs1_data_E, exp_e.rs1d);
      checkOutput("rs2_data_E", rs2_data_E, exp_e.rs2d);
      checkOutput("imm_E", imm_E, exp_e.imm);
      checkOutput("rs1_addr_E", 32'(rs1_addr_E), 32'(exp_e.rs1a));
      checkOutput("rs2_addr_E", 32'(rs2_addr_E), 32'(exp_e.rs2a));
      checkOutput("rd_addr_E", 32'(rd_addr_E), 32'(exp_e.rda));
      checkOutput("ctrl_E", 32'(ctrl_E & CTRL_MASK), 32'(exp_e.ctrl));
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: run did not finish, got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] ins;
    logic        held;
    asynch_rst = 1'b1;
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    #2 asynch_rst = 1'b0;
    #1 check_en = 1'b1;
    @(posedge clk_i);
    tick();
    checkOutput("rst valid_E", 32'(valid_E), 32'd0);
    checkOutput("rst stall", 32'(stall), 32'd0);
    checkOutput("rst pc_E", pc_E, 32'd0);
    asynch_rst = 1'b1;

    // write x5 then ADDI x6,x5,-1
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b1, 5'd5, 32'h0000_1234);
    tick();
    applyStimulus(32'hFFF28313, 32'h100, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    checkOutput("addi rs1_data", rs1_data_E, 32'h0000_1234);
    checkOutput("addi imm", imm_E, 32'hFFFF_FFFF);
    checkOutput("addi rd", 32'(rd_addr_E), 32'd6);
    checkOutput("addi valid", 32'(valid_E), 32'd1);
    checkOutput("addi ctrl", 32'(ctrl_E & CTRL_MASK), 32'h0021);

    // ADD x8,x7,x0 with same-cycle write of x7
    applyStimulus(32'h00038433, 32'h104, 1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF);
    tick();
    checkOutput("bypass rs1_data", rs1_data_E, 32'hDEAD_BEEF);
    checkOutput("bypass rd", 32'(rd_addr_E), 32'd8);

    // LW x1,0(x2) ; ADD x3,x1,x4 -> one stall, one bubble
    applyStimulus(32'h00012083, 32'h108, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    applyStimulus(32'h004081B3, 32'h10C, 1'b0, 1'b0, 5'd0, 32'd0);
    #1;
    checkOutput("loaduse stall", 32'(stall), 32'd1);
    tick();
    checkOutput("loaduse bubble valid", 32'(valid_E), 32'd0);
    checkOutput("loaduse bubble ctrl", 32'(ctrl_E), 32'd0);
    checkOutput("loaduse stall cleared", 32'(stall), 32'd0);
    tick();
    checkOutput("loaduse add valid", 32'(valid_E), 32'd1);
    checkOutput("loaduse add pc", pc_E, 32'h10C);
    checkOutput("loaduse add rd", 32'(rd_addr_E), 32'd3);

    // LW x1 ; LUI x1 -> no stall
    applyStimulus(32'h00012083, 32'h110, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    applyStimulus(32'h123450B7, 32'h114, 1'b0, 1'b0, 5'd0, 32'd0);
    #1;
    checkOutput("lui no stall", 32'(stall), 32'd0);
    tick();
    checkOutput("lui imm", imm_E, 32'h1234_5000);
    // LW x0 ; ADD x3,x0,x4 -> no stall
    applyStimulus(32'h00012003, 32'h118, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    applyStimulus(32'h004001B3, 32'h11C, 1'b0, 1'b0, 5'd0, 32'd0);
    #1;
    checkOutput("x0 no stall", 32'(stall), 32'd0);
    tick();

    // flush beats stall
    applyStimulus(32'h00012083, 32'h120, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    applyStimulus(32'h004081B3, 32'h124, 1'b1, 1'b0, 5'd0, 32'd0);
    #1;
    checkOutput("flush stall", 32'(stall), 32'd0);
    tick();
    checkOutput("flush valid", 32'(valid_E), 32'd0);
    checkOutput("flush ctrl", 32'(ctrl_E), 32'd0);

    // BEQ -8, illegal opcode, all-zero bubble
    applyStimulus(32'hFE000CE3, 32'h200, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    checkOutput("beq imm", imm_E, 32'hFFFF_FFF8);
    checkOutput("beq branch", 32'(ctrl_E[3]), 32'd1);
    applyStimulus(32'h0000007F, 32'h204, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    checkOutput("illegal flag", 32'(illegal_E), 32'd1);
    checkOutput("illegal valid", 32'(valid_E), 32'd0);
    applyStimulus(32'd0, 32'h208, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    checkOutput("zero illegal", 32'(illegal_E), 32'd0);

    // mixed instruction stream with random write-back traffic
    for (int k = 0; k < 19; k++) begin
      ins = (k < 11) ? prog[k] : 32'($urandom());
      applyStimulus(ins, 32'h300 + 32'(k * 4), (k >= 11) && ($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 32'($urandom()));
      #1;
      held = stall;
      tick();
      if (held) tick();
    end

    // reset in the middle of a stall, then decode normally
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b1, 5'd1, 32'h0000_0055);
    tick();
    applyStimulus(32'h00012083, 32'h400, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    applyStimulus(32'h004081B3, 32'h404, 1'b0, 1'b0, 5'd0, 32'd0);
    #1;
    checkOutput("pre-reset stall", 32'(stall), 32'd1);
    asynch_rst = 1'b0;
    #1;
    checkOutput("mid-reset stall", 32'(stall), 32'd0);
    checkOutput("mid-reset valid", 32'(valid_E), 32'd0);
    @(negedge clk_i);
    #1 asynch_rst = 1'b1;
    tick();
    checkOutput("post-reset valid", 32'(valid_E), 32'd1);
    checkOutput("post-reset pc", pc_E, 32'h404);
    checkOutput("post-reset rf cleared", rs1_data_E, 32'd0);
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/decode_cycle.md
DECODE_CYCLE -- requirements
Module: decode_cycle

Interface
REQ-001 The block SHALL have parameter WB_BYPASS, default 1, which enables the write-back to decode register-file bypass.
REQ-002 The block SHALL have parameter NOP_ON_ILLEGAL, default 1, which turns undecodable instructions into bubbles.
REQ-003 clk_i  input  1  clock; all state updates on the rising edge.
REQ-004 asynch_rst  input  1  reset; asynchronous, active-low.
REQ-005 instr_D  input  32  instruction from the fetch stage register; 32'd0 means bubble.
REQ-006 pc_D  input  32  PC of instr_D.
REQ-007 is_taken_E  input  1  branch/jump taken in E; flushes D.
REQ-008 rd_wren_W  input  1  write-back enable.
REQ-009 rd_addr_W  input  5  write-back destination.
REQ-010 rd_data_W  input  32  write-back data.
REQ-011 stall  output  1  hold request to fetch (combinational).
REQ-012 valid_E  output  1  D/E slot holds a real instruction.
REQ-013 pc_E  output  32  registered pc_D.
REQ-014 rs1_data_E  output  32  registered rs1 operand.
REQ-015 rs2_data_E  output  32  registered rs2 operand.
REQ-016 imm_E  output  32  registered sign-extended immediate.
REQ-017 rs1_addr_E  output  5  registered rs1 index.
REQ-018 rs2_addr_E  output  5  registered rs2 index.
REQ-019 rd_addr_E  output  5  registered rd index.
REQ-020 ctrl_E  output  16  registered control fields: [0] reg_wren, [1] mem_read, [2] mem_write, [3] branch, [4] jump, [5] alu_src_imm, [6] op_a_pc, [8:7] wb_sel (0 ALU, 1 MEM, 2 PC+4), [12:9] alu_op, [15:13] funct3.
REQ-021 illegal_E  output  1  registered flag marking an undecodable opcode.

Function
REQ-022 The register file SHALL hold 32x32 bits, with x0 reading 0 always and writes to x0 ignored.
REQ-023 Register-file writes SHALL occur on the clk_i rising edge when rd_wren_W=1.
REQ-024 With WB_BYPASS=1, a read SHALL return rd_data_W when rd_wren_W=1, rd_addr_W equals the read index, and the index is nonzero.
REQ-025 Decode SHALL support RV32I opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
REQ-026 The immediate SHALL be formed by opcode type:
- I: instr[31:20] sign-extended.
- S: {instr[31:25], instr[11:7]} sign-extended.
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 0} sign-extended.
- U: {instr[31:12], 12'b0}.
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 0} sign-extended.
REQ-027 Load-use hazard: stall SHALL be 1 when all of the following hold, else 0:
- ctrl_E[1]=1 and valid_E=1;
- rd_addr_E != 0;
- rd_addr_E equals a source register that the current instruction actually reads.
REQ-028 While stall=1 and is_taken_E=0, the D/E register SHALL load a bubble.
REQ-029 A bubble SHALL set valid_E=0 and ctrl_E=0; other fields are don't-care but held at 0.
REQ-030 When is_taken_E=1, the D/E register SHALL load a bubble and stall SHALL be forced to 0; flush has priority over stall.
REQ-031 instr_D=32'd0 SHALL produce a bubble with illegal_E=0.
REQ-032 For an unknown nonzero opcode, illegal_E SHALL be 1 for that slot; with NOP_ON_ILLEGAL=1, valid_E=0 and ctrl_E=0.
REQ-033 Otherwise, on each rising edge, the D/E register SHALL capture the decoded fields; decode-to-E latency is 1 cycle.
REQ-034 A stall SHALL last exactly 1 cycle per load-use pair, because the bubble clears ctrl_E[1] on the next cycle.

Reset
REQ-035 While asynch_rst=0, the following SHALL be cleared immediately: all D/E outputs, valid_E, illegal_E, and all 32 register-file entries.
REQ-036 stall SHALL therefore read 0 during reset.
REQ-037 Reset asserted mid-stall SHALL clear state, and the first post-release edge SHALL decode instr_D normally.

Verification
REQ-038 Reset, then write x5=0x0000_1234 via W, then decode ADDI x6,x5,-1 (0xFFF28313) -> next cycle rs1_data_E=0x1234, imm_E=0xFFFF_FFFF, rd_addr_E=6, valid_E=1.
REQ-039 Same-cycle W write x7=0xDEAD_BEEF while decoding ADD x8,x7,x0 -> rs1_data_E=0xDEAD_BEEF (bypass).
REQ-040 LW x1,0(x2) followed by ADD x3,x1,x4 -> stall=1 for exactly one cycle, one bubble (valid_E=0) enters E, then ADD appears with valid_E=1.
REQ-041 LW x1 followed by LUI x1 (no rs use) -> stall stays 0; the same pair with rd=x0 -> stall stays 0.
REQ-042 is_taken_E=1 with load-use hazard present -> stall=0, next valid_E=0, ctrl_E=0.
REQ-043 BEQ with offset -8 (0xFE000CE3) -> imm_E=0xFFFF_FFF8, ctrl_E[3]=1; opcode 7'b1111111 -> illegal_E=1, valid_E=0.
